// File: rtl/cocofdc_pkg.sv
// Shared definitions for the Coco FDC SRAM arbiter: FSM encoding, port roles
// and default access timing.
package cocofdc_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam int PORT_AVR = 0;
    localparam int PORT_SCS = 1;
    localparam int PORT_CTS = 2;

    localparam int DEF_RD_TICKS = 6;
    localparam int DEF_WR_TICKS = 4;
    localparam int DEF_SYNC     = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/coco_sram_arbiter_sel_sync_edge.sv
// Synchroniser for one asynchronous sel_n strobe, producing a one-cycle pulse
// on each synchronised falling edge.
module sel_sync_edge
    import cocofdc_pkg::*;
#(
    parameter int SYNC = DEF_SYNC
) (
    input  logic clock_50,
    input  logic c_reset_n,
    input  logic sel_n,
    output logic fall
);

    logic [SYNC-1:0] sync_reg;

    always_ff @(posedge clock_50 or negedge c_reset_n) begin
        if (!c_reset_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC-2:0], sel_n};
        end
    end

    // Top stage is the history bit, so pending lands SYNC cycles after the pin edge.
    assign fall = sync_reg[SYNC-1] & ~sync_reg[SYNC-2];

endmodule

// File: rtl/coco_sram_arbiter.sv
// N-port arbiter for the shared Coco FDC SRAM: per-port request capture,
// fixed or round-robin grant, and a counted read/write access sequencer.
module coco_sram_arbiter
    import cocofdc_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int RD_TICKS = DEF_RD_TICKS,
    parameter int WR_TICKS = DEF_WR_TICKS,
    parameter int SYNC     = DEF_SYNC,
    parameter int RR_MODE  = 0
) (
    input  logic               clock_50,
    input  logic               c_reset_n,
    input  logic [NREQ-1:0]    sel_n,
    input  logic [NREQ-1:0]    rw,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ*DW-1:0] rdata,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    pending,
    output logic [NREQ-1:0]    overrun,
    input  logic [NREQ-1:0]    ovr_clr,
    output logic [AW-1:0]      sram_addrbus,
    output logic [DW-1:0]      sram_dout,
    output logic               sram_dout_en,
    input  logic [DW-1:0]      sram_din,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               busy
);

    localparam int CW = $clog2(max2(RD_TICKS, WR_TICKS) + 1);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] fall;
    logic [NREQ-1:0] grant_vec;
    logic [IW-1:0]   win;
    logic            found;
    logic            grant;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [IW-1:0]   cur_reg;
    logic [IW-1:0]   last_reg;
    logic            rd_reg;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_sync
            sel_sync_edge #(.SYNC(SYNC)) u_sync (
                .clock_50  (clock_50),
                .c_reset_n (c_reset_n),
                .sel_n     (sel_n[gi]),
                .fall      (fall[gi])
            );
        end
    endgenerate

    always_comb begin
        win   = '0;
        found = 1'b0;
        if (RR_MODE != 0) begin
            // Scan starts just past the last granted port and wraps.
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && pending[(int'(last_reg) + k) % NREQ]) begin
                    win   = IW'((int'(last_reg) + k) % NREQ);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (pending[k]) begin
                    win = IW'(k);
                end
            end
        end
    end

    assign grant = (state_reg == ST_IDLE) && (|pending);

    always_comb begin
        grant_vec = '0;
        if (grant) begin
            grant_vec[win] = 1'b1;
        end
    end

    // A fresh edge on the port being granted re-queues it rather than overrunning.
    always_ff @(posedge clock_50 or negedge c_reset_n) begin
        if (!c_reset_n) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~grant_vec) | fall;
            overrun <= (overrun & ~ovr_clr) | (fall & pending & ~grant_vec);
        end
    end

    always_ff @(posedge clock_50 or negedge c_reset_n) begin
        if (!c_reset_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            cur_reg      <= '0;
            last_reg     <= IW'(NREQ - 1);
            rd_reg       <= 1'b0;
            sram_addrbus <= '0;
            sram_dout    <= '0;
            sram_dout_en <= 1'b0;
            sram_we_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            busy         <= 1'b0;
            done         <= '0;
            rdata        <= '0;
        end else begin
            done <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant) begin
                        state_reg    <= ST_ACCESS;
                        cur_reg      <= win;
                        last_reg     <= win;
                        rd_reg       <= rw[win];
                        sram_addrbus <= addr[win*AW +: AW];
                        sram_dout    <= wdata[win*DW +: DW];
                        busy         <= 1'b1;
                        if (rw[win]) begin
                            cnt_reg   <= CW'(RD_TICKS);
                            sram_oe_n <= 1'b0;
                        end else begin
                            cnt_reg      <= CW'(WR_TICKS);
                            sram_we_n    <= 1'b0;
                            sram_dout_en <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    // Entering the final tick: pulse done and release we_n for hold.
                    if (cnt_reg == CW'(2)) begin
                        done[cur_reg] <= 1'b1;
                        sram_we_n     <= 1'b1;
                    end
                    if (cnt_reg == CW'(1)) begin
                        state_reg    <= ST_IDLE;
                        busy         <= 1'b0;
                        sram_oe_n    <= 1'b1;
                        sram_we_n    <= 1'b1;
                        sram_dout_en <= 1'b0;
                        if (rd_reg) begin
                            rdata[cur_reg*DW +: DW] <= sram_din;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign sram_ce_n = 1'b0;

endmodule

// File: tb/tb_coco_sram_arbiter.sv
// Scenario bench for coco_sram_arbiter: a fixed-priority and a round-robin
// instance share stimulus; expected grants are queued and popped on done.
module tb_coco_sram_arbiter;
    import cocofdc_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 16;
    localparam int DW   = 8;

    typedef struct {
        int         port;
        bit         is_read;
        logic [7:0] data;
    } exp_t;

    logic              clock_50  = 1'b0;
    logic              c_reset_n = 1'b0;
    logic [NREQ-1:0]   sel_n     = '1;
    logic [NREQ-1:0]   rw        = '1;
    logic [NREQ-1:0]   ovr_clr   = '0;
    logic [NREQ*AW-1:0] addr     = '0;
    logic [NREQ*DW-1:0] wdata    = '0;
    logic              use_fixed = 1'b0;
    logic [7:0]        fixed_din = 8'h00;

    logic [NREQ*DW-1:0] rdata, rr_rdata;
    logic [NREQ-1:0]   done, pending, overrun, rr_done, rr_pending, rr_overrun;
    logic [AW-1:0]     sram_addrbus, rr_sram_addrbus;
    logic [DW-1:0]     sram_dout, rr_sram_dout, sram_din, rr_din;
    logic              sram_dout_en, sram_we_n, sram_oe_n, sram_ce_n, busy;
    logic              rr_sram_dout_en, rr_sram_we_n, rr_sram_oe_n, rr_sram_ce_n, rr_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_oe, n_we, n_en;
    logic [7:0]  last_dout;
    logic [15:0] last_addr;
    int   done_port[$];
    int   done_cyc[$];
    int   rr_port[$];
    int   rr_exp[$];
    exp_t exp_q[$];

    // SRAM model: read data is a fixed function of the address unless overridden.
    assign sram_din = use_fixed ? fixed_din : (sram_addrbus[7:0] ^ 8'h5A);
    assign rr_din   = rr_sram_addrbus[7:0] ^ 8'h5A;

    always #10 clock_50 = ~clock_50;

    coco_sram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RR_MODE(0)) dut (
        .clock_50(clock_50), .c_reset_n(c_reset_n), .sel_n(sel_n), .rw(rw),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
        .pending(pending), .overrun(overrun), .ovr_clr(ovr_clr),
        .sram_addrbus(sram_addrbus), .sram_dout(sram_dout),
        .sram_dout_en(sram_dout_en), .sram_din(sram_din),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ce_n(sram_ce_n), .busy(busy)
    );

    coco_sram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RR_MODE(1)) dut_rr (
        .clock_50(clock_50), .c_reset_n(c_reset_n), .sel_n(sel_n), .rw(rw),
        .addr(addr), .wdata(wdata), .rdata(rr_rdata), .done(rr_done),
        .pending(rr_pending), .overrun(rr_overrun), .ovr_clr(ovr_clr),
        .sram_addrbus(rr_sram_addrbus), .sram_dout(rr_sram_dout),
        .sram_dout_en(rr_sram_dout_en), .sram_din(rr_din),
        .sram_we_n(rr_sram_we_n), .sram_oe_n(rr_sram_oe_n),
        .sram_ce_n(rr_sram_ce_n), .busy(rr_busy)
    );

    task automatic clear_logs();
        n_oe = 0; n_we = 0; n_en = 0;
        last_dout = 8'h00; last_addr = 16'h0000;
        done_port.delete(); done_cyc.delete(); rr_port.delete();
    endtask

    task automatic apply_reset();
        c_reset_n = 1'b0;
        sel_n = '1;
        ovr_clr = '0;
        repeat (2) @(negedge clock_50);
        c_reset_n = 1'b1;
        @(negedge clock_50);
        clear_logs();
    endtask

    task automatic pulse(input int p, input int dly, input int width);
        repeat (dly) @(negedge clock_50);
        sel_n[p] = 1'b0;
        repeat (width) @(negedge clock_50);
        sel_n[p] = 1'b1;
    endtask

    task automatic collect(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock_50);
            cyc++;
            if (!sram_oe_n) n_oe++;
            if (!sram_we_n) n_we++;
            if (sram_dout_en) begin n_en++; last_dout = sram_dout; end
            if (busy) last_addr = sram_addrbus;
            for (int p = 0; p < NREQ; p++) begin
                if (done[p]) begin
                    done_port.push_back(p);
                    done_cyc.push_back(cyc);
                    $display("[%0d] fixed: done port %0d addr %h", cyc, p, sram_addrbus);
                end
                if (rr_done[p]) begin
                    rr_port.push_back(p);
                    $display("[%0d] rr: done port %0d addr %h", cyc, p, rr_sram_addrbus);
                end
            end
        end
    endtask

    task automatic test_reset();
        c_reset_n = 1'b0;
        repeat (3) @(negedge clock_50);
        checks++;
        if ({sram_we_n, sram_oe_n, sram_dout_en, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_ctrl we/oe/en/busy=%b expected 1100", {sram_we_n, sram_oe_n, sram_dout_en, busy});
        end
        checks++;
        if (sram_addrbus !== 16'h0 || sram_dout !== 8'h0) begin
            errors++;
            $display("FAIL reset_bus addr=%h dout=%h expected 0 0", sram_addrbus, sram_dout);
        end
        checks++;
        if (rdata !== '0 || done !== '0 || pending !== '0 || overrun !== '0) begin
            errors++;
            $display("FAIL reset_ports rdata=%h done=%b pend=%b ovr=%b expected all 0", rdata, done, pending, overrun);
        end
        checks++;
        if ({rr_sram_we_n, rr_sram_oe_n, rr_sram_dout_en, rr_busy} !== 4'b1100 ||
            rr_rdata !== '0 || rr_pending !== '0 || rr_overrun !== '0 || rr_sram_dout !== 8'h0) begin
            errors++;
            $display("FAIL reset_rr ctrl=%b rdata=%h pend=%b ovr=%b dout=%h expected 1100 0 0 0 0",
                     {rr_sram_we_n, rr_sram_oe_n, rr_sram_dout_en, rr_busy}, rr_rdata, rr_pending, rr_overrun, rr_sram_dout);
        end
        checks++;
        if (sram_ce_n !== 1'b0 || rr_sram_ce_n !== 1'b0) begin
            errors++;
            $display("FAIL ce_tied ce_n=%b/%b expected 0/0", sram_ce_n, rr_sram_ce_n);
        end
        c_reset_n = 1'b1;
        @(negedge clock_50);
        clear_logs();
    endtask

    task automatic test_single_read();
        exp_t e;
        int   p;
        use_fixed = 1'b1;
        fixed_din = 8'hA5;
        rw[PORT_CTS] = 1'b1;
        addr[PORT_CTS*AW +: AW] = 16'h8123;
        exp_q.push_back('{PORT_CTS, 1'b1, 8'hA5});
        fork
            pulse(PORT_CTS, 1, 3);
            collect(30);
        join
        while (done_port.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = done_port.pop_front();
            checks++;
            if (p !== e.port) begin errors++; $display("FAIL read_port got %0d expected %0d", p, e.port); end
            checks++;
            if (rdata[e.port*DW +: DW] !== e.data) begin
                errors++; $display("FAIL read_data got %h expected %h", rdata[e.port*DW +: DW], e.data);
            end
        end
        checks++;
        if (exp_q.size() != 0 || done_port.size() != 0) begin
            errors++; $display("FAIL read_count left_exp=%0d extra_done=%0d expected 0 0", exp_q.size(), done_port.size());
        end
        checks++;
        if (n_oe != 6) begin errors++; $display("FAIL read_oe_ticks got %0d expected 6", n_oe); end
        checks++;
        if (last_addr !== 16'h8123) begin errors++; $display("FAIL read_addr got %h expected 8123", last_addr); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after got %b expected 0", busy); end
        use_fixed = 1'b0;
    endtask

    task automatic test_single_write();
        exp_t e;
        int   p;
        clear_logs();
        rw[PORT_AVR] = 1'b0;
        addr[PORT_AVR*AW +: AW] = 16'h0011;
        wdata[PORT_AVR*DW +: DW] = 8'h3C;
        exp_q.push_back('{PORT_AVR, 1'b0, 8'h3C});
        fork
            pulse(PORT_AVR, 1, 3);
            collect(30);
        join
        while (done_port.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = done_port.pop_front();
            checks++;
            if (p !== e.port) begin errors++; $display("FAIL write_port got %0d expected %0d", p, e.port); end
            checks++;
            if (last_dout !== e.data) begin errors++; $display("FAIL write_dout got %h expected %h", last_dout, e.data); end
        end
        checks++;
        if (exp_q.size() != 0 || done_port.size() != 0) begin
            errors++; $display("FAIL write_count left_exp=%0d extra_done=%0d expected 0 0", exp_q.size(), done_port.size());
        end
        checks++;
        if (n_we != 3 || n_en != 4 || n_oe != 0) begin
            errors++; $display("FAIL write_strobes we=%0d en=%0d oe=%0d expected 3 4 0", n_we, n_en, n_oe);
        end
        checks++;
        if (last_addr !== 16'h0011) begin errors++; $display("FAIL write_addr got %h expected 0011", last_addr); end
        checks++;
        if (rdata[PORT_CTS*DW +: DW] !== 8'hA5 || rdata[PORT_AVR*DW +: DW] !== 8'h00) begin
            errors++; $display("FAIL rdata_held got %h expected a5 at port 2, 00 at port 0", rdata);
        end
        rw[PORT_AVR] = 1'b1;
    endtask

    task automatic test_same_cycle();
        exp_t e;
        int   p;
        logic [15:0] a;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            a = 16'h1000 + 16'(i * 16'h11);
            addr[i*AW +: AW] = a;
            rw[i] = 1'b1;
            exp_q.push_back('{i, 1'b1, a[7:0] ^ 8'h5A});
        end
        fork
            begin sel_n = '0; repeat (2) @(negedge clock_50); sel_n = '1; end
            collect(40);
        join
        checks++;
        if (done_cyc.size() != 3) begin
            errors++; $display("FAIL order_count got %0d expected 3", done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[1] - done_cyc[0] != 7 || done_cyc[2] - done_cyc[1] != 7) begin
                errors++; $display("FAIL order_spacing got %0d,%0d expected 7,7",
                                   done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
            end
        end
        while (done_port.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = done_port.pop_front();
            checks++;
            if (p !== e.port) begin errors++; $display("FAIL order_port got %0d expected %0d", p, e.port); end
            checks++;
            if (rdata[e.port*DW +: DW] !== e.data) begin
                errors++; $display("FAIL order_rdata port %0d got %h expected %h", e.port, rdata[e.port*DW +: DW], e.data);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_round_robin();
        int p1_fixed;
        apply_reset();
        rw = '1;
        addr[0 +: AW] = 16'h0100;
        addr[AW +: AW] = 16'h0201;
        rr_exp = '{0, 1, 0, 1};
        fork
            for (int i = 0; i < 20; i++) begin
                sel_n[1:0] = 2'b00;
                repeat (2) @(negedge clock_50);
                sel_n[1:0] = 2'b11;
                repeat (2) @(negedge clock_50);
            end
            collect(80);
        join
        checks++;
        if (rr_port.size() < 4) begin
            errors++; $display("FAIL rr_count got %0d expected >=4", rr_port.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                int ex;
                ex = rr_exp.pop_front();
                checks++;
                if (rr_port[k] !== ex) begin
                    errors++; $display("FAIL rr_grant%0d got %0d expected %0d", k, rr_port[k], ex);
                end
            end
        end
        p1_fixed = 0;
        foreach (done_port[k]) if (done_port[k] == 1) p1_fixed++;
        checks++;
        if (done_port.size() < 4 || p1_fixed != 0) begin
            errors++; $display("FAIL fixed_starve grants=%0d port1=%0d expected >=4 and 0", done_port.size(), p1_fixed);
        end
        rr_exp.delete();
    endtask

    task automatic test_overrun();
        exp_t e;
        int   p;
        apply_reset();
        rw = '1;
        addr[0 +: AW] = 16'h0040;
        addr[AW +: AW] = 16'h0051;
        exp_q.push_back('{PORT_AVR, 1'b1, 8'h40 ^ 8'h5A});
        exp_q.push_back('{PORT_SCS, 1'b1, 8'h51 ^ 8'h5A});
        fork
            pulse(PORT_AVR, 0, 2);
            begin pulse(PORT_SCS, 2, 2); pulse(PORT_SCS, 2, 2); end
            collect(40);
        join
        while (done_port.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = done_port.pop_front();
            checks++;
            if (p !== e.port) begin errors++; $display("FAIL ovr_port got %0d expected %0d", p, e.port); end
            checks++;
            if (rdata[e.port*DW +: DW] !== e.data) begin
                errors++; $display("FAIL ovr_rdata got %h expected %h", rdata[e.port*DW +: DW], e.data);
            end
        end
        checks++;
        if (exp_q.size() != 0 || done_port.size() != 0) begin
            errors++; $display("FAIL ovr_count left_exp=%0d extra_done=%0d expected 0 0", exp_q.size(), done_port.size());
        end
        checks++;
        if (overrun !== 3'b010 || pending !== 3'b000) begin
            errors++; $display("FAIL ovr_sticky ovr=%b pend=%b expected 010 000", overrun, pending);
        end
        ovr_clr[PORT_SCS] = 1'b1;
        @(negedge clock_50);
        ovr_clr = '0;
        checks++;
        if (overrun !== 3'b000) begin errors++; $display("FAIL ovr_clear got %b expected 000", overrun); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        int   p;
        int   waited;
        apply_reset();
        rw[PORT_SCS] = 1'b0;
        addr[PORT_SCS*AW +: AW] = 16'h0077;
        wdata[PORT_SCS*DW +: DW] = 8'h99;
        waited = 0;
        fork
            pulse(PORT_SCS, 0, 2);
            collect(30);
            begin
                while (!busy && waited < 20) begin @(negedge clock_50); waited++; end
                checks++;
                if (!busy) begin
                    errors++; $display("FAIL midrst_start busy=%b expected 1 within 20 cycles", busy);
                end else begin
                    @(negedge clock_50);
                    checks++;
                    if (sram_we_n !== 1'b0) begin errors++; $display("FAIL midrst_pre we_n=%b expected 0", sram_we_n); end
                    c_reset_n = 1'b0;
                    #1;
                    checks++;
                    if ({sram_we_n, sram_dout_en, busy} !== 3'b100 || pending !== '0) begin
                        errors++; $display("FAIL midrst_abort we/en/busy=%b pend=%b expected 100 000",
                                           {sram_we_n, sram_dout_en, busy}, pending);
                    end
                    repeat (2) @(negedge clock_50);
                    c_reset_n = 1'b1;
                end
            end
        join
        checks++;
        if (done_port.size() != 0) begin errors++; $display("FAIL midrst_nodone got %0d done expected 0", done_port.size()); end
        clear_logs();
        exp_q.push_back('{PORT_SCS, 1'b0, 8'h99});
        fork
            pulse(PORT_SCS, 1, 2);
            collect(30);
        join
        while (done_port.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            p = done_port.pop_front();
            checks++;
            if (p !== e.port || last_dout !== e.data) begin
                errors++; $display("FAIL midrst_retry port=%0d dout=%h expected %0d %h", p, last_dout, e.port, e.data);
            end
        end
        checks++;
        if (exp_q.size() != 0 || n_we != 3) begin
            errors++; $display("FAIL midrst_retry_count left_exp=%0d we=%0d expected 0 3", exp_q.size(), n_we);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_same_cycle();
        test_round_robin();
        test_overrun();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
